// File: rtl/gpu_apb_master.sv
// gpu_apb_master: buffers 32-bit GPU command words and issues each as an APB write to a fixed address.
module gpu_apb_master #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] CMD_ADDR = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                cmd_data_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic                       hold_i,
    output logic [31:0]                pAddr_o,
    output logic [31:0]                pDataWrite_o,
    output logic                       pSel_o,
    output logic                       pEnable_o,
    output logic                       pWrite_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       sent_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state_q;
    logic [31:0]     mem_q [DEPTH];
    logic [AW-1:0]   rd_q, wr_q, rd_nxt;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop, chain;
    logic [31:0]     next_head;
    logic [31:0]     addr_q, data_q;
    logic            sel_q, en_q, wr_en_q, sent_q;

    assign cmd_ready_o = !rst && (count_q != CW'(DEPTH));
    assign push        = cmd_valid_i && cmd_ready_o;
    assign pop         = state_q == ACCESS;
    assign count_d     = count_q + CW'(push) - CW'(pop);
    assign rd_nxt      = rd_q + AW'(1);
    // After a pop the new head is either still stored or is the word arriving on this very edge.
    assign next_head   = (count_q > CW'(1)) ? mem_q[rd_nxt] : cmd_data_i;
    assign chain       = (count_d != '0) && !hold_i;

    assign pAddr_o      = addr_q;
    assign pDataWrite_o = data_q;
    assign pSel_o       = sel_q;
    assign pEnable_o    = en_q;
    assign pWrite_o     = wr_en_q;
    assign sent_o       = sent_q;
    assign count_o      = count_q;
    assign busy_o       = (count_q != '0) || (state_q != IDLE);

    // Storage array: written on every accepted push.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= cmd_data_i;
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_nxt;
            count_q <= count_d;
        end
    end

    // Transfer FSM with registered APB outputs; head is popped on the edge that ends ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            en_q    <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            sent_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0 && !hold_i) begin
                        state_q <= SETUP;
                        sel_q   <= 1'b1;
                        wr_en_q <= 1'b1;
                        addr_q  <= CMD_ADDR;
                        data_q  <= mem_q[rd_q];
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
                    en_q    <= 1'b1;
                    sent_q  <= 1'b1;
                end
                default: begin
                    sent_q <= 1'b0;
                    en_q   <= 1'b0;
                    if (chain) begin
                        state_q <= SETUP;
                        data_q  <= next_head;
                    end else begin
                        state_q <= IDLE;
                        sel_q   <= 1'b0;
                        wr_en_q <= 1'b0;
                        addr_q  <= '0;
                        data_q  <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gpu_apb_master.sv
// tb_gpu_apb_master: directed stimulus with a queue-based reference model checked every cycle.
module tb_gpu_apb_master;
    localparam int          DEPTH = 8;
    localparam logic [31:0] ADDR  = 32'hC0DE_0040;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cmd_data_i;
    logic        cmd_valid_i, cmd_ready_o, hold_i;
    logic [31:0] pAddr_o, pDataWrite_o;
    logic        pSel_o, pEnable_o, pWrite_o, busy_o, sent_o;
    logic [3:0]  count_o;

    int checks = 0;
    int passed = 0;
    int sent_cnt = 0;
    int base;

    gpu_apb_master #(.DEPTH(DEPTH), .CMD_ADDR(ADDR)) dut (
        .clk(clk), .rst(rst),
        .cmd_data_i(cmd_data_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .hold_i(hold_i),
        .pAddr_o(pAddr_o), .pDataWrite_o(pDataWrite_o),
        .pSel_o(pSel_o), .pEnable_o(pEnable_o), .pWrite_o(pWrite_o),
        .busy_o(busy_o), .count_o(count_o), .sent_o(sent_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a === e) passed++;
        else $display("FAIL %s actual=%h expected=%h at %0t", n, a, e, $time);
    endtask

    // Reference model: pending words, and the phase of the word on the bus (0 idle, 1 setup, 2 access).
    logic [31:0] mq[$];
    logic [31:0] exp_q[$];
    int          ph = 0;
    logic [31:0] cur = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            exp_q.delete();
            ph = 0;
            cur = '0;
        end else begin
            bit pu, go;
            pu = cmd_valid_i && (mq.size() < DEPTH);
            go = (ph == 0) && (mq.size() != 0) && !hold_i;
            if (ph == 2) void'(mq.pop_front());
            if (pu) begin
                mq.push_back(cmd_data_i);
                exp_q.push_back(cmd_data_i);
            end
            if (ph == 0) ph = go ? 1 : 0;
            else if (ph == 1) ph = 2;
            else ph = (mq.size() != 0 && !hold_i) ? 1 : 0;
            if (ph == 1 && (go || !pu || 1)) cur = (ph == 1) ? mq[0] : cur;
        end
    end

    always @(negedge clk) begin
        bit act;
        act = ph != 0;
        chk("pSel", pSel_o, act);
        chk("pEnable", pEnable_o, ph == 2);
        chk("pWrite", pWrite_o, act);
        chk("pAddr", pAddr_o, act ? ADDR : 32'h0);
        chk("pData", pDataWrite_o, act ? cur : 32'h0);
        chk("sent", sent_o, ph == 2);
        chk("count", count_o, mq.size());
        chk("ready", cmd_ready_o, !rst && mq.size() < DEPTH);
        chk("busy", busy_o, mq.size() != 0 || act);
        if (sent_o === 1'b1) begin
            sent_cnt++;
            chk("order_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("order", pDataWrite_o, exp_q.pop_front());
        end
    end

    task automatic push(input logic [31:0] w);
        cmd_valid_i = 1'b1;
        cmd_data_i  = w;
        @(posedge clk);
        #2;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy_o) break;
        end
        chk("drain", busy_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        cmd_valid_i = 1'b0;
        cmd_data_i  = '0;
        hold_i      = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", cmd_ready_o, 1);
        chk("rst_count", count_o, 0);
        chk("rst_psel", pSel_o, 0);

        push(32'h1234_5678);
        @(negedge clk);
        chk("s_n0_psel", pSel_o, 0);
        chk("s_n0_count", count_o, 1);
        @(negedge clk);
        chk("s_setup_psel", pSel_o, 1);
        chk("s_setup_pen", pEnable_o, 0);
        chk("s_setup_data", pDataWrite_o, 32'h1234_5678);
        chk("s_setup_addr", pAddr_o, ADDR);
        @(negedge clk);
        chk("s_acc_pen", pEnable_o, 1);
        chk("s_acc_sent", sent_o, 1);
        chk("s_acc_data", pDataWrite_o, 32'h1234_5678);
        @(negedge clk);
        chk("s_idle_psel", pSel_o, 0);
        chk("s_idle_sent", sent_o, 0);
        chk("s_idle_busy", busy_o, 0);

        base = sent_cnt;
        for (int i = 0; i < 8; i++) push(32'hA0 + i);
        wait_idle();
        chk("burst_n", sent_cnt - base, 8);

        hold_i = 1'b1;
        for (int i = 0; i < 9; i++) push(32'hB0 + i);
        @(negedge clk);
        chk("full_count", count_o, 8);
        chk("full_ready", cmd_ready_o, 0);
        base = sent_cnt;
        hold_i = 1'b0;
        wait_idle();
        chk("full_n", sent_cnt - base, 8);
        chk("full_empty", count_o, 0);

        push(32'hC0);
        push(32'hC1);
        hold_i = 1'b1;
        @(negedge clk);
        chk("h_setup_psel", pSel_o, 1);
        chk("h_setup_pen", pEnable_o, 0);
        @(negedge clk);
        chk("h_acc_pen", pEnable_o, 1);
        chk("h_acc_data", pDataWrite_o, 32'hC0);
        @(negedge clk);
        chk("h_idle_psel", pSel_o, 0);
        chk("h_idle_count", count_o, 1);
        repeat (3) @(negedge clk);
        chk("h_still_idle", pSel_o, 0);
        base = sent_cnt;
        hold_i = 1'b0;
        wait_idle();
        chk("h_n", sent_cnt - base, 1);

        base = sent_cnt;
        push(32'hD00);
        repeat (2) @(posedge clk);
        #2;
        push(32'hD01);
        @(negedge clk);
        chk("pp_count", count_o, 1);
        chk("pp_psel", pSel_o, 1);
        chk("pp_pen", pEnable_o, 0);
        chk("pp_data", pDataWrite_o, 32'hD01);
        for (int i = 2; i < 3 * DEPTH; i++) begin
            @(posedge clk);
            #2;
            push(32'hD00 + i);
        end
        wait_idle();
        chk("pp_n", sent_cnt - base, 3 * DEPTH);

        hold_i = 1'b1;
        for (int i = 0; i < 4; i++) push(32'hE0 + i);
        hold_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pEnable_o) break;
        end
        chk("r_wait_access", pEnable_o, 1);
        #1 rst = 1'b1;
        #1;
        chk("r_psel", pSel_o, 0);
        chk("r_pen", pEnable_o, 0);
        chk("r_data", pDataWrite_o, 0);
        chk("r_count", count_o, 0);
        chk("r_sent", sent_o, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("r_quiet_psel", pSel_o, 0);
        chk("r_quiet_count", count_o, 0);
        base = sent_cnt;
        push(32'hF0);
        wait_idle();
        chk("r_after_n", sent_cnt - base, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
